// File: rtl/down_counter.sv
// Down counter from a preset value to 0 under runstop/clear/ce/load control.
// Issues a one-cycle done pulse on expiry and can optionally wrap to MAX_COUNT.
module down_counter #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             runstop,
  input  logic             clear,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count_out,
  output logic             zero,
  output logic             done,
  output logic             running
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = STOP;
      count_d = '0;
    end else if (load) begin
      state_d = STOP;
      count_d = (load_value > MaxCount) ? MaxCount : load_value;
    end else begin
      unique case (state_q)
        STOP: begin
          if (runstop && (count_q != '0 || wrap_en)) state_d = RUN;
        end
        RUN: begin
          // Losing wrap_en at zero expires silently; it is checked before ce so
          // a count of 0 is never decremented without the wrap path.
          if (!runstop) begin
            state_d = STOP;
          end else if (count_q == '0 && !wrap_en) begin
            state_d = DONE;
          end else if (ce) begin
            if (count_q > One) begin
              count_d = count_q - One;
            end else if (count_q == One) begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = wrap_en ? RUN : DONE;
            end else begin
              count_d = MaxCount;
            end
          end
        end
        DONE: begin
          if (!runstop) state_d = STOP;
        end
        default: begin
          state_d = STOP;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STOP;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign zero      = (count_q == '0);
  assign done      = done_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry after each rising edge.
module tb_down_counter;

  logic        clk;
  logic        reset;
  logic        runstop;
  logic        clear;
  logic        ce;
  logic        load;
  logic [15:0] load_value;
  logic        wrap_en;
  logic [15:0] count_out;
  logic        zero;
  logic        done;
  logic        running;

  typedef struct {
    string       name;
    logic [15:0] count;
    logic        done;
    logic        running;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  down_counter #(.WIDTH(16), .MAX_COUNT(9999)) dut (
    .clk        (clk),
    .reset      (reset),
    .runstop    (runstop),
    .clear      (clear),
    .ce         (ce),
    .load       (load),
    .load_value (load_value),
    .wrap_en    (wrap_en),
    .count_out  (count_out),
    .zero       (zero),
    .done       (done),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs (at a falling edge) and queues the state
  // expected right after the following rising edge.
  task automatic applyStimulus(input string name, input logic rs, input logic cl,
                               input logic c, input logic ld, input logic [15:0] lv,
                               input logic we, input logic [15:0] expCount,
                               input logic expDone, input logic expRunning);
    exp_t e;
    runstop    = rs;
    clear      = cl;
    ce         = c;
    load       = ld;
    load_value = lv;
    wrap_en    = we;
    e.name     = name;
    e.count    = expCount;
    e.done     = expDone;
    e.running  = expRunning;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.name, ".count"},   32'(count_out), 32'(e.count));
      checkOutput({e.name, ".zero"},    32'(zero),      32'(e.count == 16'd0));
      checkOutput({e.name, ".done"},    32'(done),      32'(e.done));
      checkOutput({e.name, ".running"}, 32'(running),   32'(e.running));
    end
  end

  initial begin
    reset = 1'b0; runstop = 1'b0; clear = 1'b0; ce = 1'b0;
    load = 1'b0; load_value = 16'd0; wrap_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.count",   32'(count_out), 32'd0);
    checkOutput("rst.zero",    32'(zero),      32'd1);
    checkOutput("rst.running", 32'(running),   32'd0);
    checkOutput("rst.done",    32'(done),      32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Idle after reset; run request at 0 without wrap stays stopped
    applyStimulus("idle",       0,0,0,0,16'd0,0, 16'd0,0,0);
    applyStimulus("run0_nowrap",1,0,1,0,16'd0,0, 16'd0,0,0);
    applyStimulus("run0_nowrap2",1,0,1,0,16'd0,0,16'd0,0,0);

    // Countdown from 5 to expiry
    applyStimulus("ld5",   0,0,0,1,16'd5,0, 16'd5,0,0);
    applyStimulus("c5_ent",1,0,1,0,16'd0,0, 16'd5,0,1);
    applyStimulus("c5_4",  1,0,1,0,16'd0,0, 16'd4,0,1);
    applyStimulus("c5_3",  1,0,1,0,16'd0,0, 16'd3,0,1);
    applyStimulus("c5_2",  1,0,1,0,16'd0,0, 16'd2,0,1);
    applyStimulus("c5_1",  1,0,1,0,16'd0,0, 16'd1,0,1);
    applyStimulus("c5_0",  1,0,1,0,16'd0,0, 16'd0,1,0);
    applyStimulus("c5_dn", 1,0,1,0,16'd0,0, 16'd0,0,0);
    applyStimulus("c5_dn2",1,0,1,0,16'd0,0, 16'd0,0,0);
    applyStimulus("c5_stp",0,0,0,0,16'd0,0, 16'd0,0,0);

    // Wrap from 2 through 0 to MAX_COUNT
    applyStimulus("ld2",    0,0,0,1,16'd2,1, 16'd2,0,0);
    applyStimulus("w_ent",  1,0,1,0,16'd0,1, 16'd2,0,1);
    applyStimulus("w_1",    1,0,1,0,16'd0,1, 16'd1,0,1);
    applyStimulus("w_0",    1,0,1,0,16'd0,1, 16'd0,1,1);
    applyStimulus("w_9999", 1,0,1,0,16'd0,1, 16'd9999,0,1);
    applyStimulus("w_9998", 1,0,1,0,16'd0,1, 16'd9998,0,1);

    // Load saturation, exact maximum, and clear beating load
    applyStimulus("ld20000",0,0,0,1,16'd20000,0, 16'd9999,0,0);
    applyStimulus("ld9999", 0,0,0,1,16'd9999,0,  16'd9999,0,0);
    applyStimulus("clr_ld", 1,1,1,1,16'd123,0,   16'd0,0,0);
    applyStimulus("clr_aft",1,0,1,0,16'd0,0,     16'd0,0,0);

    // Pause from 100 and resume
    applyStimulus("ld100", 0,0,0,1,16'd100,0, 16'd100,0,0);
    applyStimulus("p_ent", 1,0,1,0,16'd0,0,   16'd100,0,1);
    applyStimulus("p_99",  1,0,1,0,16'd0,0,   16'd99,0,1);
    applyStimulus("p_98",  1,0,1,0,16'd0,0,   16'd98,0,1);
    applyStimulus("p_h1",  0,0,1,0,16'd0,0,   16'd98,0,0);
    applyStimulus("p_h2",  0,0,1,0,16'd0,0,   16'd98,0,0);
    applyStimulus("p_h3",  0,0,1,0,16'd0,0,   16'd98,0,0);
    applyStimulus("p_rent",1,0,1,0,16'd0,0,   16'd98,0,1);
    applyStimulus("p_97",  1,0,1,0,16'd0,0,   16'd97,0,1);
    applyStimulus("p_96",  1,0,1,0,16'd0,0,   16'd96,0,1);

    // Dropping wrap_en while at 0 in RUN expires without a pulse
    applyStimulus("wd_ld1",0,0,0,1,16'd1,1, 16'd1,0,0);
    applyStimulus("wd_ent",1,0,1,0,16'd0,1, 16'd1,0,1);
    applyStimulus("wd_0",  1,0,1,0,16'd0,1, 16'd0,1,1);
    applyStimulus("wd_off",1,0,1,0,16'd0,0, 16'd0,0,0);

    // Hold at 37 in RUN with ce low, then asynchronous reset between edges
    applyStimulus("ld37",  0,0,0,1,16'd37,0, 16'd37,0,0);
    applyStimulus("h_ent", 1,0,0,0,16'd0,0,  16'd37,0,1);
    applyStimulus("h_37",  1,0,0,0,16'd0,0,  16'd37,0,1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst.count",   32'(count_out), 32'd0);
    checkOutput("arst.zero",    32'(zero),      32'd1);
    checkOutput("arst.done",    32'(done),      32'd0);
    checkOutput("arst.running", 32'(running),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus("post_rst",1,0,1,0,16'd0,0, 16'd0,0,0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
